mmio_countdown_timer: RTL and testbench
=======================================

Name: mmio_countdown_timer

Overview:
- Memory-mapped 32-bit countdown timer peripheral; reached through the system bridge from the CPU data port (address/write-data/write-enable in, read-data out).
- Drives one level/pulse interrupt line into the top-level interrupt vector (HW interrupt bits alongside external interrupt).
- Two instances are expected per system; each is distinguished by its BASE parameter.

Parameters:
- BASE, 32'h0000_7F00, word-aligned base address; decodes 16-byte window BASE..BASE+0xF.
- RESET_PRESET, 32'h0, PRESET value after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- addr  input  30  CPU word address (byte address bits [31:2]).
- we  input  1  write strobe from bridge (already qualified for this device).
- wdata  input  32  write data.
- rdata  output  32  read data, combinational from addr.
- irq  output  1  interrupt request to CPU.

Behaviour:
- Decode: hit = (addr[29:2] == BASE[31:4]); word index = addr[1:0]. 0 = CTRL (R/W), 1 = PRESET (R/W), 2 = COUNT (RO), 3 = PRESCALE (only with the optional feature, else reserved).
- CTRL bits: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as one-shot), [3] IM (irq mask). Bits [31:4] read 0, writes ignored.
- rdata: selected register when hit, else 32'h0. Reserved word and miss both read 0.
- Writes: taken on the edge where we & hit. COUNT writes are ignored. A PRESET write during counting affects only the next load.
- Reset (synchronous): CTRL = 0, PRESET = RESET_PRESET, COUNT = 0, state IDLE, irq_flag = 0, so irq = 0 and rdata for COUNT = 0.
- FSM: IDLE, LOAD, CNT, INT.
  - IDLE: EN=1 -> LOAD; otherwise hold. COUNT is frozen.
  - LOAD: COUNT <= PRESET; -> CNT. If EN=0 -> IDLE.
  - CNT: EN=0 -> IDLE, COUNT frozen. Else if COUNT > 1: COUNT <= COUNT-1. Else (COUNT ≤ 1): COUNT <= 0, irq_flag <= 1, -> INT.
  - INT, one-shot: CTRL.EN <= 0; -> IDLE. irq_flag holds until any CTRL write or reset.
  - INT, auto-reload: irq_flag <= 0 on the next edge (1-cycle pulse); -> IDLE, which reloads because EN is still 1.
- irq = irq_flag & CTRL.IM, combinational from registers.
- Latency: CTRL write with EN=1 at edge E0 -> LOAD after E1 -> COUNT=PRESET after E2 -> irq high after edge E(PRESET+2) for PRESET ≥ 1. PRESET=0 behaves as PRESET=1.
- Auto-reload period: PRESET+3 cycles between irq pulses (INT, IDLE, LOAD overhead).
- Any CTRL write clears irq_flag, including a write in the same cycle the flag would be set; the write wins.
- CTRL write with EN=0 during CNT: COUNT freezes at its current value next cycle. Re-enabling reloads from PRESET (no resume).
- Reset asserted in any state: all registers return to reset values on that edge, regardless of we.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined: word 3 is PRESCALE (R/W, 16-bit, upper bits read 0, reset 0). An internal 16-bit prescale counter gates each CNT decrement and the terminal check to once every PRESCALE+1 cycles. The prescale counter is cleared in LOAD and when EN=0. PRESCALE=0 gives timing identical to the macro-undefined build.
- Undefined: word 3 reads 0, writes are ignored, and there is no prescale logic.

Test Plan:
- Reset, then read all 4 words -> CTRL=0, PRESET=RESET_PRESET, COUNT=0, word3=0; irq=0.
- PRESET=5, CTRL=32'h9 (EN, one-shot, IM) -> irq rises 7 cycles after the CTRL-write edge and stays high; CTRL reads 32'h8 (EN cleared); writing CTRL=0 drops irq the next cycle.
- PRESET=3, CTRL=32'hB (auto-reload, IM) -> 1-cycle irq pulses every 6 cycles; COUNT sequence 3,2,1,0 repeats.
- PRESET=10, start, write CTRL=0 after 4 decrements -> COUNT frozen at 6, no irq. Write CTRL=32'h9 -> reloads 10 and irq 12 cycles later.
- IM=0 one-shot PRESET=2 -> irq stays 0; then write CTRL=32'h8 -> flag cleared, irq remains 0. Writes to addr outside the BASE window change no register and read 0.
- (TIMER_PRESCALE_EN) PRESCALE=2, PRESET=2, CTRL=32'h9 -> COUNT decrements every 3 cycles; irq ~2+2·3 cycles after start, checked against the model.

Source files
------------

// File: rtl/mmio_countdown_timer.sv
// rtl/mmio_countdown_timer.sv - memory-mapped 32-bit countdown timer with interrupt
//
// Purpose: a countdown timer reached through the CPU bridge. CTRL, PRESET and COUNT
// sit in a 4-word window starting at BASE. COUNT runs down from PRESET. When it
// expires the timer raises an interrupt flag, gated onto irq by CTRL.IM.
//
// Ports:
//   clk    in   1   system clock, all state changes on the rising edge
//   reset  in   1   synchronous active-high reset
//   addr   in  30   CPU word address (byte address bits [31:2])
//   we     in   1   write strobe, already qualified for this device
//   wdata  in  32   write data
//   rdata  out 32   read data, combinational from addr (0 on a miss or reserved word)
//   irq    out  1   interrupt request (irq_flag & CTRL.IM)
//
// Register map (word index = addr[1:0]):
//   0 CTRL     [0] EN, [2:1] MODE (01 auto-reload, others one-shot), [3] IM
//   1 PRESET   reload value
//   2 COUNT    read-only current count
//   3 PRESCALE 16-bit divider, present only when TIMER_PRESCALE_EN is defined
//
// Optional feature macro: TIMER_PRESCALE_EN
module mmio_countdown_timer #(
  parameter logic [31:0] BASE         = 32'h0000_7F00,
  parameter logic [31:0] RESET_PRESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CNT, ST_INT} state_t;

  state_t      state;
  state_t      state_next;
  logic        ctrl_en;
  logic [1:0]  ctrl_mode;
  logic        ctrl_im;
  logic [31:0] preset;
  logic [31:0] count;
  logic [31:0] count_next;
  logic        irq_flag;
  logic        irq_flag_next;
  logic        en_clear;
  logic        hit;
  logic [1:0]  word;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        auto_reload;
  logic        tick;

  assign hit         = (addr[29:2] == BASE[31:4]);
  assign word        = addr[1:0];
  assign wr_ctrl     = we & hit & (word == 2'd0);
  assign wr_preset   = we & hit & (word == 2'd1);
  assign auto_reload = (ctrl_mode == 2'b01);

`ifdef TIMER_PRESCALE_EN
  logic [15:0] prescale;
  logic [15:0] pscnt;
  logic [15:0] pscnt_next;
  logic        wr_prescale;

  assign wr_prescale = we & hit & (word == 2'd3);
  // The decrement and the terminal check both fire only on the divider tick.
  assign tick        = (pscnt == prescale);

  always_comb begin
    pscnt_next = pscnt;
    if (!ctrl_en || state == ST_LOAD) begin
      pscnt_next = '0;
    end else if (state == ST_CNT) begin
      pscnt_next = tick ? 16'd0 : pscnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= '0;
      pscnt    <= '0;
    end else begin
      pscnt <= pscnt_next;
      if (wr_prescale) begin
        prescale <= wdata[15:0];
      end
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Next-state logic. EN low always drops back to IDLE with COUNT frozen.
  // LOAD with EN already cleared does not load.
  always_comb begin
    state_next    = state;
    count_next    = count;
    irq_flag_next = irq_flag;
    en_clear      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctrl_en) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!ctrl_en) begin
          state_next = ST_IDLE;
        end else begin
          count_next = preset;
          state_next = ST_CNT;
        end
      end
      ST_CNT: begin
        if (!ctrl_en) begin
          state_next = ST_IDLE;
        end else if (tick) begin
          if (count > 32'd1) begin
            count_next = count - 32'd1;
          end else begin
            // A PRESET of 0 lands here on the first tick, so it behaves like 1.
            count_next    = 32'd0;
            irq_flag_next = 1'b1;
            state_next    = ST_INT;
          end
        end
      end
      ST_INT: begin
        // Auto-reload leaves EN set so IDLE restarts the cycle on its own.
        if (auto_reload) begin
          irq_flag_next = 1'b0;
        end else begin
          en_clear = 1'b1;
        end
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ctrl_en   <= 1'b0;
      ctrl_mode <= 2'b00;
      ctrl_im   <= 1'b0;
      preset    <= RESET_PRESET;
      count     <= 32'd0;
      irq_flag  <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      // A CTRL write beats both the flag set and the one-shot EN clear.
      if (wr_ctrl) begin
        ctrl_en   <= wdata[0];
        ctrl_mode <= wdata[2:1];
        ctrl_im   <= wdata[3];
        irq_flag  <= 1'b0;
      end else begin
        irq_flag <= irq_flag_next;
        if (en_clear) begin
          ctrl_en <= 1'b0;
        end
      end
      if (wr_preset) begin
        preset <= wdata;
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (word)
        2'd0: rdata = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
        2'd1: rdata = preset;
        2'd2: rdata = count;
`ifdef TIMER_PRESCALE_EN
        2'd3: rdata = {16'd0, prescale};
`endif
        default: rdata = 32'd0;
      endcase
    end
  end

  assign irq = irq_flag & ctrl_im;

endmodule

// File: tb/tb_mmio_countdown_timer.sv
// tb/tb_mmio_countdown_timer.sv - self-checking bench for mmio_countdown_timer
module tb_mmio_countdown_timer;

  localparam logic [31:0] BASE         = 32'h0001_2340;
  localparam logic [31:0] RESET_PRESET = 32'h0000_0007;
  localparam logic [29:0] BW           = BASE[31:2];
`ifdef TIMER_PRESCALE_EN
  localparam logic [31:0] W3_EXP = 32'h0000_ABCD;
`else
  localparam logic [31:0] W3_EXP = 32'h0;
`endif

  logic        clk;
  logic        reset;
  logic [29:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_pass;
  int n_total;

  mmio_countdown_timer #(.BASE(BASE), .RESET_PRESET(RESET_PRESET)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .wdata(wdata),
    .rdata(rdata),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  // Reference model: timeline view. m_ph counts edges since the timer was armed
  // (-1 = stopped). Edge 2 loads PRESET, the irq lands at edge max(P,1)+2, and
  // the edge after that ends the interrupt.
  logic        m_en;
  logic [1:0]  m_mode;
  logic        m_im;
  logic        m_flag;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic [31:0] m_raw;
  longint      m_ph;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [29:0] a, input logic w, input logic [31:0] d,
                              input logic [31:0] er, input logic ei);
    vec_t v;
    v.addr = a; v.we = w; v.wdata = d; v.exp_rdata = er; v.exp_irq = ei;
    return v;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] w, input logic [31:0] d);
    @(negedge clk);
    addr = BW + 30'(w); we = 1'b1; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic chk_rd(input string name, input logic [1:0] w, input logic [31:0] exp);
    addr = BW + 30'(w);
    #1;
    chk(name, rdata, exp);
  endtask

  task automatic chk_irq(input string name, input logic exp);
    #1;
    chk(name, {31'd0, irq}, {31'd0, exp});
  endtask

  task automatic model_reset();
    m_en = 0; m_mode = 0; m_im = 0; m_flag = 0;
    m_preset = RESET_PRESET; m_count = 0; m_raw = 0; m_ph = -1;
  endtask

  task automatic model_step(input logic rst, input logic [29:0] a, input logic w_e,
                            input logic [31:0] d);
    longint pl;
    logic   hit;
    if (rst) begin
      model_reset();
      return;
    end
    hit = (a[29:2] == BASE[31:4]);
    if (!m_en) begin
      m_ph = -1;
    end else begin
      m_ph = m_ph + 1;
      if (m_ph == 2) begin
        m_raw   = m_preset;
        m_count = m_preset;
      end else if (m_ph > 2) begin
        pl = (m_raw == 32'd0) ? 64'sd1 : longint'(m_raw);
        if (m_ph < pl + 2) begin
          m_count = m_raw - 32'(m_ph - 2);
        end else if (m_ph == pl + 2) begin
          m_count = 0;
          m_flag  = 1;
        end else if (m_mode == 2'b01) begin
          m_flag = 0;
          m_ph   = 0;
        end else begin
          m_en = 0;
          m_ph = -1;
        end
      end
    end
    if (w_e && hit && a[1:0] == 2'd0) begin
      m_en   = d[0];
      m_mode = d[2:1];
      m_im   = d[3];
      m_flag = 0;
      if (m_en && m_ph < 0) m_ph = 0;
    end
    if (w_e && hit && a[1:0] == 2'd1) m_preset = d;
  endtask

  function automatic logic [31:0] model_read(input logic [29:0] a);
    if (a[29:2] != BASE[31:4]) return 32'd0;
    case (a[1:0])
      2'd0: return {28'd0, m_im, m_mode, m_en};
      2'd1: return m_preset;
      2'd2: return m_count;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    n_pass = 0; n_total = 0;
    addr = BW + 30'd1; we = 1'b1; wdata = 32'hFFFF_FFFF; reset = 1'b1;
    cyc(3);
    reset = 1'b0; we = 1'b0;

    // Static register behaviour while the timer is disabled.
    vecs.push_back(mk(BW + 30'd0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(BW + 30'd1, 0, 0, RESET_PRESET, 0));
    vecs.push_back(mk(BW + 30'd2, 0, 0, 32'h0, 0));
    vecs.push_back(mk(BW + 30'd3, 0, 0, 32'h0, 0));
    vecs.push_back(mk(BW + 30'd1, 1, 32'h0000_1234, RESET_PRESET, 0));
    vecs.push_back(mk(BW + 30'd1, 0, 0, 32'h0000_1234, 0));
    vecs.push_back(mk(BW + 30'd2, 1, 32'h0000_0055, 32'h0, 0));
    vecs.push_back(mk(BW + 30'd2, 0, 0, 32'h0, 0));
    vecs.push_back(mk(BW + 30'd5, 1, 32'h0000_DEAD, 32'h0, 0));
    vecs.push_back(mk(BW + 30'd1, 0, 0, 32'h0000_1234, 0));
    vecs.push_back(mk((BW ^ 30'h100) + 30'd1, 1, 32'h0000_BEEF, 32'h0, 0));
    vecs.push_back(mk(BW + 30'd1, 0, 0, 32'h0000_1234, 0));
    vecs.push_back(mk(BW + 30'd0, 1, 32'hFFFF_FFF6, 32'h0, 0));
    vecs.push_back(mk(BW + 30'd0, 0, 0, 32'h0000_0006, 0));
    vecs.push_back(mk(BW + 30'd0, 1, 32'h0, 32'h0000_0006, 0));
    vecs.push_back(mk(BW + 30'd3, 1, 32'hFFFF_ABCD, 32'h0, 0));
    vecs.push_back(mk(BW + 30'd3, 0, 0, W3_EXP, 0));
    vecs.push_back(mk(BW + 30'd3, 1, 32'h0, W3_EXP, 0));
    vecs.push_back(mk(BW - 30'd1, 0, 0, 32'h0, 0));
    vecs.push_back(mk(BW + 30'd0, 0, 0, 32'h0, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      addr = vecs[i].addr; we = vecs[i].we; wdata = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
    end
    @(negedge clk);
    we = 1'b0;

    // One-shot, PRESET=5: irq 7 edges after the CTRL write, sticky until CTRL write.
    wr(1, 32'd5);
    wr(0, 32'h9);
    cyc(6);
    chk_irq("os_irq_e6", 0);
    chk_rd("os_count_e6", 2, 32'd1);
    cyc(1);
    chk_irq("os_irq_e7", 1);
    chk_rd("os_count_e7", 2, 32'd0);
    cyc(3);
    chk_irq("os_irq_sticky", 1);
    chk_rd("os_ctrl_en_cleared", 0, 32'h8);
    wr(0, 32'h0);
    chk_irq("os_irq_cleared", 0);

    // Auto-reload, PRESET=3: 1-cycle pulses every 6 cycles.
    wr(1, 32'd3);
    wr(0, 32'hB);
    for (int k = 1; k <= 20; k++) begin
      int r;
      logic [31:0] ec;
      cyc(1);
      r  = (k - 2) % 6;
      ec = (k < 2) ? 32'd0 : ((r <= 3) ? 32'(3 - r) : 32'd0);
      chk_irq($sformatf("ar_irq_k%0d", k), (k >= 5) && ((k - 5) % 6 == 0));
      chk_rd($sformatf("ar_count_k%0d", k), 2, ec);
    end
    wr(0, 32'h0);

    // Stop mid-count freezes COUNT; re-enable reloads from PRESET.
    wr(1, 32'd10);
    wr(0, 32'h9);
    cyc(4);
    wr(0, 32'h0);
    chk_rd("stop_count_e6", 2, 32'd6);
    cyc(5);
    chk_rd("stop_count_frozen", 2, 32'd6);
    chk_irq("stop_no_irq", 0);
    wr(0, 32'h9);
    cyc(2);
    chk_rd("restart_reload", 2, 32'd10);
    cyc(9);
    chk_irq("restart_irq_e11", 0);
    cyc(1);
    chk_irq("restart_irq_e12", 1);
    wr(0, 32'h0);

    // Masked one-shot: flag hidden, then cleared by the unmasking CTRL write.
    wr(1, 32'd2);
    wr(0, 32'h1);
    cyc(6);
    chk_irq("masked_irq", 0);
    chk_rd("masked_ctrl", 0, 32'h0);
    wr(0, 32'h8);
    chk_irq("unmask_irq", 0);
    cyc(2);
    chk_irq("unmask_irq_later", 0);
    chk_rd("unmask_ctrl", 0, 32'h8);

`ifdef TIMER_PRESCALE_EN
    // PRESCALE=2: one decrement every 3 cycles, irq at 2 + 2*3 edges.
    wr(3, 32'd2);
    wr(1, 32'd2);
    wr(0, 32'h9);
    cyc(4);
    chk_rd("ps_count_e4", 2, 32'd2);
    cyc(1);
    chk_rd("ps_count_e5", 2, 32'd1);
    cyc(2);
    chk_irq("ps_irq_e7", 0);
    cyc(1);
    chk_irq("ps_irq_e8", 1);
    wr(0, 32'h0);
    wr(3, 32'h0);
`endif

    // Randomised traffic against the timeline model, with occasional resets.
    model_reset();
    for (int c = 0; c < 2500; c++) begin
      int r;
      @(negedge clk);
      reset = (c < 2) || ($urandom_range(0, 599) == 0);
      r     = $urandom_range(0, 31);
      wdata = $urandom;
      we    = 1'b0;
      if ($urandom_range(0, 4) == 0) addr = BW ^ (30'd1 << $urandom_range(2, 29));
      else addr = BW + 30'($urandom_range(0, 3));
      case (r)
        0: begin
          addr = BW; we = 1'b1;
          wdata[0] = ($urandom_range(0, 3) != 0);
        end
        1: begin
          addr = BW + 30'd1; we = 1'b1;
          wdata = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 12));
        end
        2: begin addr = BW + 30'd2; we = 1'b1; end
        3: begin addr = (BW ^ (30'd1 << $urandom_range(2, 29))) + 30'($urandom_range(0, 3)); we = 1'b1; end
        default: ;
      endcase
      if (reset) we = $urandom_range(0, 1) == 1;
      #1;
      if (c >= 1) begin
        chk($sformatf("rnd%0d_rdata", c), rdata, model_read(addr));
        chk($sformatf("rnd%0d_irq", c), {31'd0, irq}, {31'd0, m_flag & m_im});
      end
      @(posedge clk);
      model_step(reset, addr, we, wdata);
    end
    @(negedge clk);
    reset = 1'b0; we = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
